// File: rtl/hyper_pkg.sv
// Shared types and helpers for the hyper_mvblck_todram_p LSAB-to-DRAM burst mover.
package hyper_pkg;

    localparam int ADDR_W_DEF = 12;
    localparam int CNT_W_DEF  = 6;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WAIT  = 3'd1,
        ST_READ  = 3'd2,
        ST_FLUSH = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

    // Lane enable bit `idx` of the expanded mask; slot 0 occupies the MSB lanes.
    function automatic logic lane_en(input logic [15:0] slots, input int idx,
                                     input int burst, input int lanes);
        return slots[burst - 1 - (idx / lanes)];
    endfunction

endpackage

// File: rtl/hyper_mvblck_todram_p_burst_pack.sv
// Collects per-slot valid bits into a burst and registers the MCU write request.
module hyper_burst_pack
    import hyper_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int BURST_LOG2 = 1,
    parameter int LANES      = 2,
    localparam int BURST     = 1 << BURST_LOG2,
    localparam int WE_W      = BURST * LANES
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              rd_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic              flush_i,
    output logic [ADDR_W-1:0] coll_addr_o,
    output logic [WE_W-1:0]   we_o,
    output logic              req_o
);

    logic [BURST-1:0]  slot_mask_q, slot_mask_d;
    logic [ADDR_W-1:0] coll_addr_q, coll_addr_d;
    logic [WE_W-1:0]   we_q, we_d, we_exp_s;
    logic              req_q, req_d;
    logic [BURST-1:0]  slot_bit_s, mask_sel_s;
    logic              close_s;
    logic [ADDR_W-1:0] base_s;

    assign slot_bit_s = BURST'(1'b1) << addr_i[BURST_LOG2-1:0];
    assign close_s    = rd_i && (&addr_i[BURST_LOG2-1:0]);
    assign mask_sel_s = close_s ? (slot_mask_q | slot_bit_s) : slot_mask_q;
    // After a flush the pointer still sits inside the unfinished burst, so its base is valid.
    assign base_s     = {addr_i[ADDR_W-1:BURST_LOG2], {BURST_LOG2{1'b0}}};

    // Replicate each slot bit across its lanes.
    always_comb begin
        we_exp_s = '0;
        for (int i = 0; i < WE_W; i++) begin
            we_exp_s[i] = lane_en(16'(mask_sel_s), i, BURST, LANES);
        end
    end

    // Burst accumulation and request generation.
    always_comb begin
        slot_mask_d = slot_mask_q;
        coll_addr_d = coll_addr_q;
        we_d        = we_q;
        req_d       = 1'b0;
        if (close_s) begin
            req_d       = 1'b1;
            coll_addr_d = base_s;
            we_d        = we_exp_s;
            slot_mask_d = '0;
        end else if (rd_i) begin
            slot_mask_d = slot_mask_q | slot_bit_s;
        end else if (flush_i && (slot_mask_q != '0)) begin
            req_d       = 1'b1;
            coll_addr_d = base_s;
            we_d        = we_exp_s;
            slot_mask_d = '0;
        end else begin
            slot_mask_d = slot_mask_q;
        end
    end

    // Registers with synchronous active-low reset.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            slot_mask_q <= '0;
            coll_addr_q <= '0;
            we_q        <= '0;
            req_q       <= 1'b0;
        end else begin
            slot_mask_q <= slot_mask_d;
            coll_addr_q <= coll_addr_d;
            we_q        <= we_d;
            req_q       <= req_d;
        end
    end

    assign coll_addr_o = coll_addr_q;
    assign we_o        = we_q;
    assign req_o       = req_q;

endmodule

// File: rtl/hyper_mvblck_todram_p.sv
// LSAB section to DRAM block mover with burst packing, start timeout and DONE pulse.
// Optional ABORT input is enabled by defining HYPER_MVBLCK_ABORT_EN.
module hyper_mvblck_todram_p
    import hyper_pkg::*;
#(
    parameter int         SECTIONS   = 4,
    parameter int         ADDR_W     = ADDR_W_DEF,
    parameter int         CNT_W      = CNT_W_DEF,
    parameter int         BURST_LOG2 = 1,
    parameter int         LANES      = 2,
    parameter logic [7:0] STALL_MAX  = 8'd15,
    localparam int        SEC_W      = $clog2(SECTIONS),
    localparam int        WE_W       = (1 << BURST_LOG2) * LANES
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [SECTIONS-1:0] LSAB_STOP,
    output logic              LSAB_READ,
    output logic [SEC_W-1:0]  LSAB_SECTION,
    input  logic [ADDR_W-1:0] START_ADDRESS,
    input  logic [CNT_W-1:0]  COUNT_REQ,
    input  logic [SEC_W-1:0]  SECTION,
    input  logic              ISSUE,
    output logic [CNT_W-1:0]  COUNT_SENT,
    output logic              WORKING,
    output logic              DONE,
    output logic [ADDR_W-1:0] MCU_COLL_ADDRESS,
    output logic [WE_W-1:0]   MCU_WE_ARRAY,
    output logic              MCU_REQUEST_ACCESS
`ifdef HYPER_MVBLCK_ABORT_EN
    ,
    input  logic              ABORT
`endif
);

    state_e            state_q, state_d;
    logic [SEC_W-1:0]  sec_q, sec_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CNT_W-1:0]  len_q, len_d;
    logic [ADDR_W-1:0] track_q, track_d;
    logic [7:0]        stall_q, stall_d;
    logic              rd_q, rd_d;
    logic              working_q, done_q;
    logic [CNT_W-1:0]  sent_q;
    logic              stop_n_s, abort_s, rd_strobe_s, flush_s;

`ifdef HYPER_MVBLCK_ABORT_EN
    assign abort_s = ABORT;
`else
    assign abort_s = 1'b0;
`endif

    assign stop_n_s = (len_q != '0) && !LSAB_STOP[sec_q];

    // Next-state and read decision.
    always_comb begin
        state_d     = state_q;
        sec_d       = sec_q;
        cnt_d       = cnt_q;
        len_d       = len_q;
        track_d     = track_q;
        stall_d     = stall_q;
        rd_d        = 1'b0;
        rd_strobe_s = 1'b0;
        flush_s     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                sec_d   = SECTION;
                cnt_d   = COUNT_REQ;
                len_d   = COUNT_REQ;
                track_d = START_ADDRESS;
                stall_d = 8'd0;
                if (ISSUE) begin
                    state_d = (COUNT_REQ == '0) ? ST_DONE : ST_WAIT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT, ST_READ: begin
                if (abort_s) begin
                    state_d = ST_FLUSH;
                end else if (stop_n_s) begin
                    rd_d        = 1'b1;
                    rd_strobe_s = 1'b1;
                    track_d     = track_q + ADDR_W'(1);
                    len_d       = len_q - CNT_W'(1);
                    state_d     = ST_READ;
                end else if (state_q == ST_READ) begin
                    state_d = ST_FLUSH;
                end else if (stall_q == STALL_MAX) begin
                    state_d = ST_DONE;
                end else begin
                    stall_d = stall_q + 8'd1;
                end
            end
            ST_FLUSH: begin
                flush_s = 1'b1;
                state_d = ST_DONE;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, counters and registered status outputs.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q   <= ST_IDLE;
            sec_q     <= '0;
            cnt_q     <= '0;
            len_q     <= '0;
            track_q   <= '0;
            stall_q   <= 8'd0;
            rd_q      <= 1'b0;
            working_q <= 1'b0;
            done_q    <= 1'b0;
            sent_q    <= '0;
        end else begin
            state_q   <= state_d;
            sec_q     <= sec_d;
            cnt_q     <= cnt_d;
            len_q     <= len_d;
            track_q   <= track_d;
            stall_q   <= stall_d;
            rd_q      <= rd_d;
            working_q <= (state_q != ST_IDLE);
            done_q    <= (state_q == ST_DONE);
            sent_q    <= (state_q == ST_DONE) ? (cnt_q - len_q) : sent_q;
        end
    end

    hyper_burst_pack #(
        .ADDR_W     (ADDR_W),
        .BURST_LOG2 (BURST_LOG2),
        .LANES      (LANES)
    ) u_pack (
        .CLK         (CLK),
        .RST         (RST),
        .rd_i        (rd_strobe_s),
        .addr_i      (track_q),
        .flush_i     (flush_s),
        .coll_addr_o (MCU_COLL_ADDRESS),
        .we_o        (MCU_WE_ARRAY),
        .req_o       (MCU_REQUEST_ACCESS)
    );

    assign LSAB_READ    = rd_q;
    assign LSAB_SECTION = sec_q;
    assign COUNT_SENT   = sent_q;
    assign WORKING      = working_q;
    assign DONE         = done_q;

endmodule

// File: tb/tb_hyper_mvblck_todram_p.sv
// Directed table-driven bench for hyper_mvblck_todram_p; ABORT cases need HYPER_MVBLCK_ABORT_EN.
module tb_hyper_mvblck_todram_p;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  lsab_stop = 4'hF;
    logic        lsab_read;
    logic [1:0]  lsab_section;
    logic [11:0] start_addr = 12'h000;
    logic [5:0]  count_req = 6'd0;
    logic [1:0]  section = 2'd0;
    logic        issue = 1'b0;
    logic [5:0]  count_sent;
    logic        working, done;
    logic [11:0] mcu_addr;
    logic [3:0]  mcu_we;
    logic        mcu_req;
`ifdef HYPER_MVBLCK_ABORT_EN
    logic        abort_r = 1'b0;
`endif

    always #5 clk = ~clk;

    hyper_mvblck_todram_p dut (
        .CLK(clk), .RST(rst_n), .LSAB_STOP(lsab_stop), .LSAB_READ(lsab_read),
        .LSAB_SECTION(lsab_section), .START_ADDRESS(start_addr), .COUNT_REQ(count_req),
        .SECTION(section), .ISSUE(issue), .COUNT_SENT(count_sent), .WORKING(working),
        .DONE(done), .MCU_COLL_ADDRESS(mcu_addr), .MCU_WE_ARRAY(mcu_we),
        .MCU_REQUEST_ACCESS(mcu_req)
`ifdef HYPER_MVBLCK_ABORT_EN
        , .ABORT(abort_r)
`endif
    );

    int n_checks = 0;
    int n_pass   = 0;

    // LSAB model and observation counters (only this block writes them).
    int          pops = 0, nreq = 0, dones = 0, b2b = 0;
    logic        prev_req = 1'b0;
    logic [11:0] ra [64];
    logic [3:0]  rw [64];
    int          cfg_sel = 0, cfg_limit = 99, pop_base = 0;
    logic        force_stop = 1'b0;

    function automatic logic [3:0] stop_vec(input int sel, input logic b);
        logic [3:0] v;
        v = 4'hF;
        v[sel] = b;
        return v;
    endfunction

    always @(negedge clk) begin
        pops <= pops + int'(lsab_read);
        if (mcu_req) begin
            if (nreq < 64) begin
                ra[nreq] <= mcu_addr;
                rw[nreq] <= mcu_we;
            end
            nreq <= nreq + 1;
            if (prev_req) b2b <= b2b + 1;
        end
        prev_req  <= mcu_req;
        dones     <= dones + int'(done);
        lsab_stop <= stop_vec(cfg_sel, force_stop ||
                              ((pops + int'(lsab_read) - pop_base) >= cfg_limit));
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    endtask

    int pops0, nreq0, dones0;

    // Starts one transfer and waits for DONE; lat = posedges after the ISSUE edge.
    task automatic run_xfer(input logic [11:0] st, input logic [5:0] cnt, input logic [1:0] sec,
                            input int limit, input logic hold, input int release_at,
                            output int lat);
        @(posedge clk); #1;
        pops0 = pops; nreq0 = nreq; dones0 = dones;
        cfg_sel = int'(sec); cfg_limit = limit; pop_base = pops; force_stop = hold;
        start_addr = st; count_req = cnt; section = sec; issue = 1'b1;
        @(posedge clk); #1;
        issue = 1'b0;
        lat = 0;
        for (int k = 1; k <= 80; k++) begin
            @(posedge clk); #2;
            if (k == release_at) force_stop = 1'b0;
            if (dones > dones0) begin
                lat = k;
                break;
            end
        end
        if (lat == 0) $display("FAIL timeout: actual=no DONE required=DONE within 80 cycles");
        repeat (3) @(posedge clk);
        #2;
    endtask

    typedef struct {
        string       name;
        logic [11:0] st;
        logic [5:0]  cnt;
        logic [1:0]  sec;
        int          limit;
        logic [5:0]  sent;
        int          nreq;
        logic [11:0] a0, a1;
        logic [3:0]  w0, w1;
        int          lat;
    } vec_t;

    vec_t vt[6];
    int   lat;

    initial begin
        // Expected latency for n reads ending normally is n+4; empty start is STALL_MAX+3.
        vt[0] = '{"aligned",   12'h010, 6'd4, 2'd2, 99, 6'd4, 2, 12'h010, 12'h012, 4'b1111, 4'b1111, 8};
        vt[1] = '{"unaligned", 12'h005, 6'd3, 2'd0, 99, 6'd3, 2, 12'h004, 12'h006, 4'b0011, 4'b1111, 7};
        vt[2] = '{"midstop",   12'h020, 6'd8, 2'd1, 3,  6'd3, 2, 12'h020, 12'h022, 4'b1111, 4'b1100, 7};
        vt[3] = '{"empty",     12'h100, 6'd5, 2'd3, 0,  6'd0, 0, 12'h000, 12'h000, 4'b0000, 4'b0000, 18};
        vt[4] = '{"count0",    12'h200, 6'd0, 2'd2, 99, 6'd0, 0, 12'h000, 12'h000, 4'b0000, 4'b0000, 2};
        vt[5] = '{"wrap",      12'hFFF, 6'd2, 2'd1, 99, 6'd2, 2, 12'hFFE, 12'h000, 4'b0011, 4'b1100, 6};

        repeat (3) @(posedge clk);
        #2;
        chk("rst_read", {31'd0, lsab_read}, 32'd0);
        chk("rst_sec", {30'd0, lsab_section}, 32'd0);
        chk("rst_sent", {26'd0, count_sent}, 32'd0);
        chk("rst_work_done", {30'd0, working, done}, 32'd0);
        chk("rst_mcu", {15'd0, mcu_req, mcu_we, mcu_addr}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 6; i++) begin
            run_xfer(vt[i].st, vt[i].cnt, vt[i].sec, vt[i].limit, 1'b0, 0, lat);
            chk({vt[i].name, "_lat"}, lat, vt[i].lat);
            chk({vt[i].name, "_sent"}, {26'd0, count_sent}, {26'd0, vt[i].sent});
            chk({vt[i].name, "_reads"}, pops - pops0, {26'd0, vt[i].sent});
            chk({vt[i].name, "_dones"}, dones - dones0, 32'd1);
            chk({vt[i].name, "_nreq"}, nreq - nreq0, vt[i].nreq);
            chk({vt[i].name, "_idle"}, {31'd0, working}, 32'd0);
            chk({vt[i].name, "_lsabsec"}, {30'd0, lsab_section}, {30'd0, vt[i].sec});
            if (vt[i].nreq > 0) begin
                chk({vt[i].name, "_a0"}, {20'd0, ra[nreq0]}, {20'd0, vt[i].a0});
                chk({vt[i].name, "_w0"}, {28'd0, rw[nreq0]}, {28'd0, vt[i].w0});
            end
            if (vt[i].nreq > 1) begin
                chk({vt[i].name, "_a1"}, {20'd0, ra[nreq0+1]}, {20'd0, vt[i].a1});
                chk({vt[i].name, "_w1"}, {28'd0, rw[nreq0+1]}, {28'd0, vt[i].w1});
            end
        end

        // Empty LSAB for 5 cycles, then data: two words at 0x040 complete normally.
        run_xfer(12'h040, 6'd2, 2'd0, 99, 1'b1, 5, lat);
        chk("late_lat", lat, 11);
        chk("late_sent", {26'd0, count_sent}, 32'd2);
        chk("late_nreq", nreq - nreq0, 1);
        chk("late_a0", {20'd0, ra[nreq0]}, 32'h040);
        chk("late_w0", {28'd0, rw[nreq0]}, 32'hF);

`ifdef HYPER_MVBLCK_ABORT_EN
        // ABORT after the first read decision.
        @(posedge clk); #1;
        pops0 = pops; nreq0 = nreq; dones0 = dones;
        cfg_sel = 2; cfg_limit = 99; pop_base = pops; force_stop = 1'b0;
        start_addr = 12'h030; count_req = 6'd6; section = 2'd2; issue = 1'b1;
        @(posedge clk); #1;
        issue = 1'b0;
        @(posedge clk); #2;
        abort_r = 1'b1;
        @(posedge clk); #2;
        abort_r = 1'b0;
        repeat (6) @(posedge clk);
        #2;
        chk("abort_sent", {26'd0, count_sent}, 32'd1);
        chk("abort_reads", pops - pops0, 32'd1);
        chk("abort_dones", dones - dones0, 32'd1);
        chk("abort_nreq", nreq - nreq0, 1);
        chk("abort_a0", {20'd0, ra[nreq0]}, 32'h030);
        chk("abort_w0", {28'd0, rw[nreq0]}, 32'hC);
`endif

        // Reset in the middle of a READ burst.
        @(posedge clk); #1;
        dones0 = dones;
        cfg_sel = 2; cfg_limit = 99; pop_base = pops; force_stop = 1'b0;
        start_addr = 12'h050; count_req = 6'd8; section = 2'd2; issue = 1'b1;
        @(posedge clk); #1;
        issue = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("pre_rst_working", {31'd0, working}, 32'd1);
        rst_n = 1'b0;
        @(posedge clk); #2;
        chk("mid_rst_read", {31'd0, lsab_read}, 32'd0);
        chk("mid_rst_status", {26'd0, count_sent, working, done}, 32'd0);
        chk("mid_rst_mcu", {15'd0, mcu_req, mcu_we, mcu_addr}, 32'd0);
        rst_n = 1'b1;
        nreq0 = nreq;
        repeat (6) @(posedge clk);
        #2;
        chk("mid_rst_nodone", dones - dones0, 32'd0);
        chk("mid_rst_noreq", nreq - nreq0, 0);
        chk("mid_rst_idle", {31'd0, working}, 32'd0);
        chk("no_back2back_req", b2b, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
